// File: rtl/div_iter_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : div_iter_unit_if                                           |
// | Description : Bundle of request, shared-adder and result signals for     |
// |               the iterative divider.                                     |
// |   slave  (divider side) : start, kill, op, dividend, divisor,            |
// |                           add_result, add_carry, [word] in;              |
// |                           add_a, add_b, add_cin, add_alu_ctl, busy,      |
// |                           done, result out.                              |
// |   master (EX stage / adder side) : the mirror image.                     |
// |   Optional macro DIV_WORD_EN adds the 'word' request signal.             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+

`ifndef SUB
`define SUB 5'b00010
`endif

interface div_iter_unit_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  start;
    logic                  kill;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
`ifdef DIV_WORD_EN
    logic                  word;
`endif
    logic [DATA_WIDTH-1:0] add_a;
    logic [DATA_WIDTH-1:0] add_b;
    logic                  add_cin;
    logic [4:0]            add_alu_ctl;
    logic [DATA_WIDTH-1:0] add_result;
    logic                  add_carry;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;

`ifdef DIV_WORD_EN
    modport slave (
        input  start, kill, op, dividend, divisor, word, add_result, add_carry,
        output add_a, add_b, add_cin, add_alu_ctl, busy, done, result
    );
    modport master (
        output start, kill, op, dividend, divisor, word, add_result, add_carry,
        input  add_a, add_b, add_cin, add_alu_ctl, busy, done, result
    );
`else
    modport slave (
        input  start, kill, op, dividend, divisor, add_result, add_carry,
        output add_a, add_b, add_cin, add_alu_ctl, busy, done, result
    );
    modport master (
        output start, kill, op, dividend, divisor, add_result, add_carry,
        input  add_a, add_b, add_cin, add_alu_ctl, busy, done, result
    );
`endif
endinterface

`default_nettype wire

// File: rtl/div_iter_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : div_iter_unit                                              |
// | Description : Iterative radix-2 restoring divider for RV64M              |
// |               DIV/DIVU/REM/REMU. Borrows the EX-stage 64-bit adder for   |
// |               its trial subtraction instead of owning a subtractor.      |
// | Ports       : clk, rst (sync, active-high)                               |
// |               bus (div_iter_unit_if.slave): start/kill/op/dividend/      |
// |               divisor request, add_* shared adder, busy/done/result.     |
// | Options     : DIV_WORD_EN adds DIVW/DIVUW/REMW/REMUW (bus.word).         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+

module div_iter_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_W      = 7
) (
    input  logic            clk,
    input  logic            rst,
    div_iter_unit_if.slave  bus
);

    localparam int HALF = DATA_WIDTH / 2;
    localparam logic [CNT_W-1:0]      c_LAST_FULL = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]      c_LAST_HALF = CNT_W'(HALF - 1);
    localparam logic [DATA_WIDTH-1:0] c_MIN_FULL  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    // Most-negative word value, already sign-extended to full width.
    localparam logic [DATA_WIDTH-1:0] c_MIN_HALF  = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    // quo_q holds the captured dividend until PREP, then the quotient shifter.
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    // dvs_q holds the captured divisor until PREP, then |divisor|.
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  negq_q, negq_d;
    logic                  negr_q, negr_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic                  w_word;
`ifdef DIV_WORD_EN
    logic                  word_q, word_d;
    assign w_word = word_q;
`else
    assign w_word = 1'b0;
`endif

    // Word results are the low half sign-extended to full width.
    function automatic logic [DATA_WIDTH-1:0] fit_width(
        input logic [DATA_WIDTH-1:0] x,
        input logic                  word
    );
        fit_width = word ? {{HALF{x[HALF-1]}}, x[HALF-1:0]} : x;
    endfunction

    // ---------------------------------------------------------------------
    // Operand conditioning used in PREP. In word mode the low halves are
    // extended (sign or zero by op) so every later step works at full width.
    // ---------------------------------------------------------------------
    logic                  w_signed;
    logic [DATA_WIDTH-1:0] w_op_a, w_op_b;
    logic                  w_neg_a, w_neg_b;
    logic [DATA_WIDTH-1:0] w_abs_a, w_abs_b;
    logic                  w_div0, w_ovf;
    logic [CNT_W-1:0]      w_last;

    assign w_signed = ~op_q[0];

    always_comb begin
        w_op_a = quo_q;
        w_op_b = dvs_q;
        if (w_word) begin
            w_op_a = {{HALF{w_signed & quo_q[HALF-1]}}, quo_q[HALF-1:0]};
            w_op_b = {{HALF{w_signed & dvs_q[HALF-1]}}, dvs_q[HALF-1:0]};
        end
    end

    assign w_neg_a = w_signed & w_op_a[DATA_WIDTH-1];
    assign w_neg_b = w_signed & w_op_b[DATA_WIDTH-1];
    assign w_abs_a = w_neg_a ? -w_op_a : w_op_a;
    assign w_abs_b = w_neg_b ? -w_op_b : w_op_b;
    assign w_div0  = (w_op_b == '0);
    assign w_ovf   = w_signed & (&w_op_b) &
                     (w_op_a == (w_word ? c_MIN_HALF : c_MIN_FULL));
    assign w_last  = w_word ? c_LAST_HALF : c_LAST_FULL;

    // ---------------------------------------------------------------------
    // Trial subtraction on the shared adder. msb is the 65th bit of the
    // shifted remainder: when set the trial always succeeds, and the low
    // DATA_WIDTH bits of the adder sum are still the exact difference.
    // ---------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_shift;
    logic                  w_msb;
    logic                  w_ok;
    logic                  w_in_calc;

    assign w_shift   = {rem_q[DATA_WIDTH-2:0], quo_q[DATA_WIDTH-1]};
    assign w_msb     = rem_q[DATA_WIDTH-1];
    assign w_ok      = w_msb | bus.add_carry;
    assign w_in_calc = (state_q == S_CALC);

    always_comb begin
        bus.add_a       = '0;
        bus.add_b       = '0;
        bus.add_cin     = 1'b0;
        bus.add_alu_ctl = 5'd0;
        if (w_in_calc) begin
            bus.add_a       = w_shift;
            bus.add_b       = ~dvs_q;
            bus.add_cin     = 1'b1;
            bus.add_alu_ctl = `SUB;
        end
    end

    // Sign fix-up of the finished quotient/remainder.
    logic [DATA_WIDTH-1:0] w_fix_q, w_fix_r;
    assign w_fix_q = negq_q ? -quo_q : quo_q;
    assign w_fix_r = negr_q ? -rem_q : rem_q;

    // ---------------------------------------------------------------------
    // Next-state and datapath
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
`ifdef DIV_WORD_EN
        word_d   = word_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.kill) begin
                    op_d    = bus.op;
                    quo_d   = bus.dividend;
                    dvs_d   = bus.divisor;
`ifdef DIV_WORD_EN
                    word_d  = bus.word;
`endif
                    state_d = S_PREP;
                end
            end

            S_PREP: begin
                if (w_div0) begin
                    result_d = fit_width(op_q[1] ? w_op_a : '1, w_word);
                    state_d  = S_DONE;
                end else if (w_ovf) begin
                    result_d = fit_width(op_q[1] ? '0 : w_op_a, w_word);
                    state_d  = S_DONE;
                end else begin
                    dvs_d   = w_abs_b;
                    // Word operands are pre-shifted so only HALF iterations
                    // are needed to walk every dividend bit into R.
                    quo_d   = w_word ? {w_abs_a[HALF-1:0], {HALF{1'b0}}} : w_abs_a;
                    rem_d   = '0;
                    cnt_d   = '0;
                    negq_d  = w_neg_a ^ w_neg_b;
                    negr_d  = w_neg_a;
                    state_d = S_CALC;
                end
            end

            S_CALC: begin
                rem_d = w_ok ? bus.add_result : w_shift;
                quo_d = {quo_q[DATA_WIDTH-2:0], w_ok};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == w_last) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                result_d = fit_width(op_q[1] ? w_fix_r : w_fix_q, w_word);
                state_d  = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush: abandon the operation and keep the previous result visible.
        if (bus.kill && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
`ifdef DIV_WORD_EN
            word_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
`ifdef DIV_WORD_EN
            word_q   <= word_d;
`endif
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;

endmodule

`default_nettype wire

// File: doc/div_iter_unit.md
Name:
div_iter_unit

Overview:
- Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU in the EX stage.
- Has no subtractor of its own. Each CALC cycle it drives the shared 64-bit adder with a trial subtraction (A=partial remainder, B=~divisor, Cin=1, ALU_CTL=`SUB).
- It consumes the adder's result and carry-out to decide each quotient bit.
- The EX stall logic holds the pipeline while busy=1.

Parameters:
- DATA_WIDTH, 64, operand/result width; must be even (word mode uses DATA_WIDTH/2).
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > DATA_WIDTH.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; accepted only when state==IDLE.
- kill  input  1  synchronous abort (pipeline flush); overrides start.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; captured at accept.
- dividend  input  DATA_WIDTH  rs1; captured at accept.
- divisor  input  DATA_WIDTH  rs2; captured at accept.
- add_a  output  DATA_WIDTH  shared adder operand A.
- add_b  output  DATA_WIDTH  shared adder operand B.
- add_cin  output  1  shared adder carry-in.
- add_alu_ctl  output  5  `SUB during CALC, else 0.
- add_result  input  DATA_WIDTH  shared adder sum.
- add_carry  input  1  shared adder carry-out (1 = no borrow).
- busy  output  1  state!=IDLE.
- done  output  1  one-cycle pulse, result valid.
- result  output  DATA_WIDTH  quotient or remainder, held until next accept.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0, add_a=0, add_b=0, add_cin=0, add_alu_ctl=0. Reset mid-operation aborts with no done pulse.
- States and transitions:
  - IDLE: start & ~kill -> PREP.
  - PREP: special case -> DONE; else -> CALC.
  - CALC: after DATA_WIDTH iterations -> FIX.
  - FIX -> DONE.
  - DONE -> IDLE.
- kill in any non-IDLE state: next state IDLE, done stays 0, result unchanged.
- Latency, with the start cycle as cycle 0:
  - Normal: PREP in cycle 1, CALC in cycles 2..DATA_WIDTH+1, FIX in cycle DATA_WIDTH+2, done=1 in cycle DATA_WIDTH+3 (67 for 64-bit).
  - Special case: done=1 in cycle 2.
- Special cases, decided in PREP from the captured operands:
  - divisor==0: quotient all ones, remainder = dividend.
  - Signed op with dividend == most-negative and divisor == -1: quotient = dividend, remainder = 0.
- PREP, normal path:
  - Signed ops: take absolute values (inline two's-complement negate). neg_q = sign(dividend) ^ sign(divisor); neg_r = sign(dividend).
  - Unsigned ops: operands used as-is; neg_q = neg_r = 0.
  - Clear the partial remainder R (DATA_WIDTH bits) and the counter.
  - Load the quotient shift register Q with |dividend|.
- CALC, each cycle:
  - Form S = {R[DATA_WIDTH-2:0], Q[DATA_WIDTH-1]}; msb = R[DATA_WIDTH-1].
  - Drive add_a=S, add_b=~|divisor|, add_cin=1, add_alu_ctl=`SUB.
  - Trial succeeds when msb | add_carry (msb covers the 65-bit case when divisor > 2^(DATA_WIDTH-1)).
  - On success: R<=add_result. On failure: R<=S.
  - Shift Q left by 1, inserting the success bit at bit 0; counter increments.
- Adder outputs are 0 outside CALC.
- FIX: quotient = neg_q ? -Q : Q; remainder = neg_r ? -R : R.
- DONE: result = op[1] ? remainder : quotient; done=1 for exactly one cycle.
- start while busy (including the DONE cycle) is ignored; it does not queue.

Optional Feature:
- Macro: DIV_WORD_EN.
- Defined:
  - Adds port word (input, 1), captured at accept, for DIVW/DIVUW/REMW/REMUW.
  - Operands are the low DATA_WIDTH/2 bits; signedness and special cases are evaluated at 32-bit width.
  - CALC runs DATA_WIDTH/2 cycles, so done lands in cycle 35.
  - The 32-bit result is sign-extended to DATA_WIDTH.
- Undefined: port absent; only 64-bit ops, fixed 64-iteration CALC.

Test Plan:
- DIVU, dividend 100, divisor 7 -> done in cycle 67, result 14; repeat with REMU -> result 2.
- REM, dividend -7, divisor 2 -> result 0xFFFF_FFFF_FFFF_FFFF (-1); DIV with the same operands -> result -3.
- DIV, divisor 0, dividend 5 -> done in cycle 2, result 0xFFFF_FFFF_FFFF_FFFF; REM with the same operands -> result 5.
- DIV, dividend 0x8000_0000_0000_0000, divisor -1 -> result 0x8000_0000_0000_0000 in cycle 2; REM with the same operands -> result 0.
- DIVU, dividend 0xFFFF_FFFF_FFFF_FFFF, divisor 0x8000_0000_0000_0001 -> result 1; REMU with the same operands -> result 0x7FFF_FFFF_FFFF_FFFE (exercises the msb path).
- Start DIVU, assert kill in cycle 30 -> busy=0 in cycle 31, no done pulse. Then start DIVU 9/3 -> result 3 in cycle 67. With DIV_WORD_EN defined, DIVW dividend 0x1_8000_0000, divisor 2 -> result 0xFFFF_FFFF_C000_0000 in cycle 35.
